level_sequencer: RTL and testbench
==================================

# level_sequencer

Game-flow state machine that produces the 2-bit `levelCode` consumed by the per-level bitmap multiplexers, i.e. the driving end of the level-select interface. It tracks the current level, player lives, the inter-level transition delay (counted in video frames) and a post-hit invulnerability window. It sits between the game-logic event sources (collision and goal detectors, start key) and every object that selects graphics or behaviour per level.

## Interface
- `TRANSITION_FRAMES`, 120: frames shown in the level-1→level-2 transition; legal range 1..255.
- `LIVES`, 3: lives at game start; legal range 1..7.
- `HIT_COOLDOWN_FRAMES`, 60: frames after a counted hit during which further hits are ignored; legal range 0..255.
- `clk` in 1: system clock; every flop is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `startGame` in 1: one-cycle pulse from the start key.
- `levelComplete` in 1: one-cycle pulse when the player reaches the level goal.
- `playerHit` in 1: one-cycle pulse on a lethal collision.
- `levelCode` out 2: 00 level one, 01 level two, 10 transition/won, 11 game over.
- `lives` out 3: remaining lives.
- `levelStartPulse` out 1: one-cycle pulse on entry to PLAY1 or PLAY2.
- `transitionActive` out 1: high in TRANS12.
- `gameWon` out 1: high in WON.
- `gameOver` out 1: high in LOST.

## Operation
- States: IDLE, PLAY1, TRANS12, PLAY2, WON, LOST. Every output is registered.
- IDLE: levelCode=00, lives=LIVES. `startGame` → PLAY1.
- PLAY1: levelCode=00.
  - `levelComplete` → TRANS12; frame counter loads TRANSITION_FRAMES.
  - A counted `playerHit` decrements lives. If lives was 1, go to LOST with lives=0.
- TRANS12: levelCode=10. Each `startOfFrame` decrements the frame counter. The pulse that brings it to 0 moves the FSM to PLAY2. Hits and levelComplete are ignored.
- PLAY2: levelCode=01. `levelComplete` → WON. Hits are handled as in PLAY1.
- WON: levelCode=10, gameWon=1. LOST: levelCode=11, gameOver=1.
  - From either state, `startGame` → PLAY1 with lives reloaded to LIVES and the cooldown cleared.
- `startGame` has no effect in PLAY1, TRANS12 or PLAY2.
- Hit cooldown:
  - A counted hit loads the cooldown counter with HIT_COOLDOWN_FRAMES. Each `startOfFrame` decrements it while it is nonzero.
  - A hit is counted only when the cooldown counter is 0 and the state is PLAY1 or PLAY2.
  - Entering PLAY2 clears the cooldown.
- `levelComplete` and `playerHit` in the same cycle: levelComplete wins and the hit is discarded.
- `levelCode` 10 and 11 are "hold" codes for the muxes: the mux keeps the last level selection.

## Timing
- Reset values: state IDLE, levelCode=00, lives=LIVES, levelStartPulse=0, transitionActive=0, gameWon=0, gameOver=0, both counters 0.
- Reset is synchronous and takes priority over all inputs in the same cycle. Reset during any state returns to IDLE on the next edge.
- Latency: the input pulse is sampled at edge N. The new state and all outputs are valid after edge N (one cycle).
- `levelStartPulse` is high exactly in the first cycle of PLAY1 or PLAY2, then low.
- Lives decrement is visible in the same cycle as a state change caused by the same hit.
- The transition lasts exactly TRANSITION_FRAMES `startOfFrame` pulses. A `startOfFrame` in the entry cycle of TRANS12 is not counted.
- `startOfFrame` coincident with a counted hit: the cooldown loads HIT_COOLDOWN_FRAMES and does not decrement in that cycle.
- HIT_COOLDOWN_FRAMES=0: every hit in PLAY states is counted.
- Counters saturate at 0 and never wrap.

## Test plan
Bench parameters: TRANSITION_FRAMES=4, LIVES=3, HIT_COOLDOWN_FRAMES=2.
- Reset, then `startGame` → next cycle levelCode=00, levelStartPulse=1 for one cycle, lives=3.
- In PLAY1, `levelComplete` → levelCode=10 and transitionActive=1. After the 4th `startOfFrame`, next cycle levelCode=01 and levelStartPulse=1.
- In PLAY1: hit (lives=2), hit 1 frame later (ignored, lives=2), hit after 2 more frames (lives=1), hit after cooldown → levelCode=11, gameOver=1, lives=0.
- `levelComplete` and `playerHit` in the same cycle in PLAY2 → WON (levelCode=10, gameWon=1) with lives unchanged. Then `startGame` → PLAY1 with lives=3.
- `reset` asserted mid-TRANS12 with the counter at 2 → next cycle IDLE, levelCode=00, transitionActive=0. A subsequent `startGame` behaves as from power-up.
- `startGame` pulsed during PLAY2 → no state change and no levelStartPulse.

Source files
------------

// File: rtl/level_sequencer.sv
// Game-flow sequencer: tracks level, lives, inter-level transition delay and
// post-hit invulnerability, and drives the per-level select code.
module level_sequencer #(
  parameter int unsigned TRANSITION_FRAMES   = 120,
  parameter int unsigned LIVES               = 3,
  parameter int unsigned HIT_COOLDOWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       levelComplete,
  input  logic       playerHit,
  output logic [1:0] levelCode,
  output logic [2:0] lives,
  output logic       levelStartPulse,
  output logic       transitionActive,
  output logic       gameWon,
  output logic       gameOver
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LIVES_W = 3;

  localparam logic [CNT_W-1:0]   TRANS_LOAD = CNT_W'(TRANSITION_FRAMES);
  localparam logic [CNT_W-1:0]   COOL_LOAD  = CNT_W'(HIT_COOLDOWN_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY1   = 3'd1,
    TRANS12 = 3'd2,
    PLAY2   = 3'd3,
    WON     = 3'd4,
    LOST    = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   frame_cnt, frame_next;
  logic [CNT_W-1:0]   cool_cnt, cool_next;
  logic [LIVES_W-1:0] lives_next;
  logic [1:0]         level_code_next;
  logic               start_pulse_next;
  logic               hit_counted;

  // Hits are ignored while invulnerable and lose to a simultaneous goal.
  assign hit_counted = playerHit && !levelComplete && (cool_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      frame_cnt        <= '0;
      cool_cnt         <= '0;
      lives            <= LIVES_INIT;
      levelCode        <= 2'b00;
      levelStartPulse  <= 1'b0;
      transitionActive <= 1'b0;
      gameWon          <= 1'b0;
      gameOver         <= 1'b0;
    end else begin
      state            <= state_next;
      frame_cnt        <= frame_next;
      cool_cnt         <= cool_next;
      lives            <= lives_next;
      levelCode        <= level_code_next;
      levelStartPulse  <= start_pulse_next;
      transitionActive <= (state_next == TRANS12);
      gameWon          <= (state_next == WON);
      gameOver         <= (state_next == LOST);
    end
  end

  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    lives_next = lives;
    cool_next  = (startOfFrame && (cool_cnt != '0)) ? cool_cnt - CNT_W'(1) : cool_cnt;

    case (state)
      IDLE: begin
        lives_next = LIVES_INIT;
        if (startGame) begin
          state_next = PLAY1;
          cool_next  = '0;
        end
      end
      PLAY1, PLAY2: begin
        if (levelComplete) begin
          if (state == PLAY1) begin
            state_next = TRANS12;
            frame_next = TRANS_LOAD;
          end else begin
            state_next = WON;
          end
        end else if (hit_counted) begin
          cool_next = COOL_LOAD;
          if (lives <= LIVES_W'(1)) begin
            lives_next = '0;
            state_next = LOST;
          end else begin
            lives_next = lives - LIVES_W'(1);
          end
        end
      end
      TRANS12: begin
        if (startOfFrame && (frame_cnt != '0)) begin
          frame_next = frame_cnt - CNT_W'(1);
          if (frame_cnt == CNT_W'(1)) begin
            state_next = PLAY2;
            cool_next  = '0;
          end
        end
      end
      WON, LOST: begin
        if (startGame) begin
          state_next = PLAY1;
          lives_next = LIVES_INIT;
          cool_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Codes 10/11 tell the bitmap muxes to hold their last level selection.
    case (state_next)
      PLAY2:        level_code_next = 2'b01;
      TRANS12, WON: level_code_next = 2'b10;
      LOST:         level_code_next = 2'b11;
      default:      level_code_next = 2'b00;
    endcase

    start_pulse_next = ((state_next == PLAY1) || (state_next == PLAY2)) && (state_next != state);
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed game scenarios with literal expectations,
// then randomized pulses checked every cycle against a behavioural game model.
module tb_level_sequencer;

  localparam int TF = 4;
  localparam int LV = 3;
  localparam int HC = 2;

  localparam int G_IDLE = 0, G_PLAY1 = 1, G_TRANS = 2, G_PLAY2 = 3, G_WON = 4, G_LOST = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startGame = 1'b0;
  logic       levelComplete = 1'b0;
  logic       playerHit = 1'b0;
  logic [1:0] levelCode;
  logic [2:0] lives;
  logic       levelStartPulse, transitionActive, gameWon, gameOver;

  int n_cmp = 0;
  int n_err = 0;

  level_sequencer #(
    .TRANSITION_FRAMES(TF),
    .LIVES(LV),
    .HIT_COOLDOWN_FRAMES(HC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .startGame(startGame),
    .levelComplete(levelComplete),
    .playerHit(playerHit),
    .levelCode(levelCode),
    .lives(lives),
    .levelStartPulse(levelStartPulse),
    .transitionActive(transitionActive),
    .gameWon(gameWon),
    .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural game model: phase, lives, frames left in transition, invulnerable frames left.
  int m_phase = G_IDLE, m_lives = LV, m_frames = 0, m_cool = 0;
  bit m_pulse = 0, m_valid = 0;

  always @(posedge clk) begin
    int np, nl, nf, nc;
    if (reset) begin
      m_phase <= G_IDLE; m_lives <= LV; m_frames <= 0; m_cool <= 0;
      m_pulse <= 0; m_valid <= 1;
    end else begin
      np = m_phase; nl = m_lives; nf = m_frames; nc = m_cool;
      if (startOfFrame && nc > 0) nc = nc - 1;
      if (m_phase == G_IDLE) begin
        nl = LV;
        if (startGame) begin np = G_PLAY1; nc = 0; end
      end else if (m_phase == G_PLAY1 || m_phase == G_PLAY2) begin
        if (levelComplete) begin
          np = (m_phase == G_PLAY1) ? G_TRANS : G_WON;
          if (m_phase == G_PLAY1) nf = TF;
        end else if (playerHit && m_cool == 0) begin
          nc = HC;
          nl = m_lives - 1;
          if (nl == 0) np = G_LOST;
        end
      end else if (m_phase == G_TRANS) begin
        if (startOfFrame && nf > 0) begin
          nf = nf - 1;
          if (nf == 0) begin np = G_PLAY2; nc = 0; end
        end
      end else if (startGame) begin
        np = G_PLAY1; nl = LV; nc = 0;
      end
      m_pulse <= (np == G_PLAY1 || np == G_PLAY2) && (np != m_phase);
      m_phase <= np; m_lives <= nl; m_frames <= nf; m_cool <= nc;
    end
  end

  function automatic int exp_code(input int ph);
    case (ph)
      G_PLAY2:         return 1;
      G_TRANS, G_WON:  return 2;
      G_LOST:          return 3;
      default:         return 0;
    endcase
  endfunction

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_levelCode", int'(levelCode), exp_code(m_phase));
      chk("m_lives", int'(lives), m_lives);
      chk("m_levelStartPulse", int'(levelStartPulse), int'(m_pulse));
      chk("m_transitionActive", int'(transitionActive), int'(m_phase == G_TRANS));
      chk("m_gameWon", int'(gameWon), int'(m_phase == G_WON));
      chk("m_gameOver", int'(gameOver), int'(m_phase == G_LOST));
    end
  end

  // One cycle of stimulus; returns #1 after the edge that sampled it.
  task automatic step(input bit r, input bit sg, input bit lc, input bit ph, input bit sof);
    @(negedge clk);
    reset = r; startGame = sg; levelComplete = lc; playerHit = ph; startOfFrame = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset values
    step(1, 0, 0, 0, 0);
    chk("rst_levelCode", int'(levelCode), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_flags", int'({levelStartPulse, transitionActive, gameWon, gameOver}), 0);

    // Start game
    step(0, 1, 0, 0, 0);
    chk("start_code", int'(levelCode), 0);
    chk("start_pulse", int'(levelStartPulse), 1);
    chk("start_lives", int'(lives), 3);
    idle_cycle();
    chk("start_pulse_drop", int'(levelStartPulse), 0);

    // Transition; a frame pulse in the entry cycle is not counted
    step(0, 0, 1, 0, 1);
    chk("trans_code", int'(levelCode), 2);
    chk("trans_active", int'(transitionActive), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("trans_still", int'(levelCode), 2);
    step(0, 0, 0, 0, 1);
    chk("play2_code", int'(levelCode), 1);
    chk("play2_pulse", int'(levelStartPulse), 1);
    chk("play2_trans_off", int'(transitionActive), 0);

    // startGame ignored in PLAY2
    idle_cycle();
    step(0, 1, 0, 0, 0);
    chk("sg_play2_code", int'(levelCode), 1);
    chk("sg_play2_pulse", int'(levelStartPulse), 0);

    // Goal beats hit
    step(0, 0, 1, 1, 0);
    chk("won_code", int'(levelCode), 2);
    chk("won_flag", int'(gameWon), 1);
    chk("won_lives", int'(lives), 3);
    step(0, 1, 0, 0, 0);
    chk("restart_code", int'(levelCode), 0);
    chk("restart_lives", int'(lives), 3);
    chk("restart_pulse", int'(levelStartPulse), 1);

    // Hit cooldown sequence
    step(0, 0, 0, 1, 0);
    chk("hit1_lives", int'(lives), 2);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("hit2_ignored", int'(lives), 2);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("hit3_lives", int'(lives), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("lost_code", int'(levelCode), 3);
    chk("lost_flag", int'(gameOver), 1);
    chk("lost_lives", int'(lives), 0);

    // Reset mid-transition with two frames remaining
    step(0, 1, 0, 0, 0);
    chk("relaunch_lives", int'(lives), 3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mid_trans", int'(transitionActive), 1);
    step(1, 0, 0, 0, 1);
    chk("rst_trans_code", int'(levelCode), 0);
    chk("rst_trans_active", int'(transitionActive), 0);
    chk("rst_trans_lives", int'(lives), 3);
    step(0, 1, 0, 0, 0);
    chk("post_rst_pulse", int'(levelStartPulse), 1);
    chk("post_rst_code", int'(levelCode), 0);

    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0));
    end
    idle_cycle();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
